// File: rtl/dcm_lock_sequencer.sv
// Lock sequencer for the second-stage DCM. It runs on the free-running
// BUS_CLK and pulses the DCM reset. It retries when lock does not arrive in
// time, and holds the downstream synchronous reset until LOCKED has been
// stable for a programmable number of cycles. It also keeps saturating
// counters of failed lock attempts and of relock events.
module dcm_lock_sequencer #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 LOCKED,
    input  logic                 CLKFX_STOPPED,
    output logic                 DCM_RST,
    output logic                 SYS_RST,
    output logic                 LOCK_OK,
    output logic [CNT_WIDTH-1:0] FAIL_CNT,
    output logic [CNT_WIDTH-1:0] RELOCK_CNT
);

    // The phase counter only has to reach (largest duration - 1).
    localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    typedef enum logic [3:0] {
        RESET_DCM = 4'b0001,
        WAIT_LOCK = 4'b0010,
        STABLE    = 4'b0100,
        RUN       = 4'b1000
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic            fail_inc;
    logic            relock_inc;
    logic            lock_p0;
    logic            lock_s;
    logic            stop_p0;
    logic            stop_s;
    logic            lock_bad;

    // Status counters stop at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] one;
        one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    // Two-flop synchronisers for the DCM status inputs (asynchronous to BUS_CLK).
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
            stop_p0 <= 1'b0;
            stop_s  <= 1'b0;
        end else begin
            lock_p0 <= LOCKED;
            lock_s  <= lock_p0;
            stop_p0 <= CLKFX_STOPPED;
            stop_s  <= stop_p0;
        end
    end

    // Lock is usable only while LOCKED is high and CLKFX is still running.
    assign lock_bad = !lock_s || stop_s;

    // Next-state, phase counter and counter-event decode.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CW'(1);
        fail_inc   = 1'b0;
        relock_inc = 1'b0;
        case (state)
            RESET_DCM: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            WAIT_LOCK: begin
                // A lock seen in the timeout cycle takes priority over the retry.
                if (!lock_bad) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_nx = RESET_DCM;
                    cnt_nx   = '0;
                    fail_inc = 1'b1;
                end
            end
            STABLE: begin
                if (lock_bad) begin
                    state_nx = RESET_DCM;
                    cnt_nx   = '0;
                    fail_inc = 1'b1;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (lock_bad) begin
                    state_nx   = RESET_DCM;
                    relock_inc = 1'b1;
                end
            end
            default: begin
                state_nx = RESET_DCM;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, phase counter and saturating status counters.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state      <= RESET_DCM;
            cnt        <= '0;
            FAIL_CNT   <= '0;
            RELOCK_CNT <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (fail_inc) begin
                FAIL_CNT <= sat_inc(FAIL_CNT);
            end
            if (relock_inc) begin
                RELOCK_CNT <= sat_inc(RELOCK_CNT);
            end
        end
    end

    // Moore outputs come straight from one-hot state flops, so they are glitch-free.
    assign DCM_RST = state[0];
    assign LOCK_OK = state[3];
    assign SYS_RST = ~state[3];

endmodule

// File: doc/dcm_lock_sequencer.md
Name: dcm_lock_sequencer

Overview:
- Downstream companion of the two-stage DCM clock generator.
- Runs on the always-present 48 MHz input clock domain and monitors the second DCM's LOCKED output and its CLKFX-stopped STATUS bit.
- Pulses that DCM's reset, retries after a lock timeout, and holds the design-wide synchronous reset until lock has been stable for a programmable time.
- Counts lock failures and relock events for status readback.

Parameters:
- RST_CYCLES, 4, number of BUS_CLK cycles DCM_RST is held high per reset attempt (DCM minimum is 3 CLKIN cycles).
- LOCK_TIMEOUT, 100000, BUS_CLK cycles allowed in WAIT_LOCK before a retry (about 2.08 ms at 48 MHz).
- STABLE_CYCLES, 1024, BUS_CLK cycles LOCKED must stay high before SYS_RST is released.
- CNT_WIDTH, 8, width of the FAIL_CNT and RELOCK_CNT status counters.

Ports:
- BUS_CLK  in  1  48 MHz input clock; never gated by the DCMs.
- BUS_RST  in  1  asynchronous, active-high reset.
- LOCKED  in  1  DCM LOCKED; asynchronous to BUS_CLK.
- CLKFX_STOPPED  in  1  DCM STATUS[2]; asynchronous to BUS_CLK.
- DCM_RST  out  1  reset to the DCM.
- SYS_RST  out  1  synchronous reset for downstream logic, active-high.
- LOCK_OK  out  1  high only in state RUN.
- FAIL_CNT  out  CNT_WIDTH  count of lock timeouts and of lock losses during STABLE; saturating.
- RELOCK_CNT  out  CNT_WIDTH  count of lock losses from RUN; saturating.

Behaviour:
- Input synchronisation:
  - LOCKED and CLKFX_STOPPED each pass through a two-flop synchroniser, producing lock_s and stop_s.
  - Synchroniser flops reset to 0.
  - Fixed 2-cycle input latency.
- State machine:
  - One-hot state register; states RESET_DCM, WAIT_LOCK, STABLE, RUN.
  - A single counter cnt is cleared on every state transition; its width is sized to the largest parameter.
- Reset (BUS_RST high, asynchronous):
  - state = RESET_DCM, cnt = 0.
  - DCM_RST = 1, SYS_RST = 1, LOCK_OK = 0, FAIL_CNT = 0, RELOCK_CNT = 0.
  - Assertion mid-operation aborts immediately to these values.
- RESET_DCM:
  - DCM_RST = 1.
  - cnt increments each cycle.
  - When cnt == RST_CYCLES-1, go to WAIT_LOCK, so DCM_RST is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - If lock_s = 1 and stop_s = 0, go to STABLE.
  - Otherwise, when cnt == LOCK_TIMEOUT-1, go to RESET_DCM and increment FAIL_CNT.
  - A lock arriving in the timeout cycle wins over the timeout.
- STABLE:
  - If lock_s = 0 or stop_s = 1, go to RESET_DCM and increment FAIL_CNT.
  - Otherwise, when cnt == STABLE_CYCLES-1, go to RUN.
- RUN:
  - If lock_s = 0 or stop_s = 1, go to RESET_DCM and increment RELOCK_CNT.
  - cnt is held at 0.
- Outputs are Moore decodes, registered via the one-hot state bits, so they are glitch-free:
  - DCM_RST = state RESET_DCM.
  - LOCK_OK = state RUN.
  - SYS_RST = NOT state RUN.
  - SYS_RST falls in the first cycle the state is RUN and rises in the first cycle after leaving RUN.
- Status counters:
  - Both counters saturate at all-ones; no wrap.
  - They are cleared only by BUS_RST.
  - Simultaneous events in one cycle increment at most one counter, as selected by the current state.
- Latencies:
  - LOCKED rising edge to state STABLE: 3 cycles (2 synchroniser + 1 transition).
  - LOCKED falling edge in RUN to SYS_RST high: 3 cycles.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, CNT_WIDTH=4.
1. Release BUS_RST with LOCKED=1 constant:
   - DCM_RST high for 4 cycles.
   - Then WAIT_LOCK for 1 cycle and STABLE for 8 cycles.
   - SYS_RST falls exactly 13 cycles after the first cycle with BUS_RST low.
   - LOCK_OK=1, FAIL_CNT=0.
2. LOCKED held 0:
   - DCM_RST pulses 4 high / 16 low, repeating.
   - FAIL_CNT increments once per period and saturates at 15 after 15 timeouts.
   - SYS_RST stays 1 throughout.
3. In RUN, drop LOCKED for 1 cycle:
   - SYS_RST rises 3 cycles later; DCM_RST pulses for 4 cycles; RELOCK_CNT=1.
   - With LOCKED back, SYS_RST falls again after the full STABLE period.
4. In STABLE at cnt=5, drop LOCKED:
   - Returns to RESET_DCM; FAIL_CNT=1; RELOCK_CNT=0.
   - SYS_RST never deasserts.
5. In RUN, assert CLKFX_STOPPED with LOCKED=1:
   - Same response as scenario 3: SYS_RST rises 3 cycles later, DCM_RST pulses for 4 cycles, RELOCK_CNT increments.
6. Assert BUS_RST mid-STABLE and mid-RUN:
   - All outputs return to reset values asynchronously; counters clear.
   - Full sequence restarts as in scenario 1.
